// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding the write side of an async FIFO
//
// Parameters: NREQ (2..8) requesters, DATASIZE word width, BURST (1..16) max beats per grant.
// Ports:
//   wclk      write-domain clock, rising edge
//   wrst_n    asynchronous active-low reset
//   req       per-requester write request
//   wdata_in  flattened requester data, slice i*DATASIZE belongs to requester i
//   wfull     FIFO full flag
//   gnt       one-hot accept; the granted word is written this cycle
//   winc      FIFO write increment (|gnt)
//   wdata     selected word, zero when winc=0
//   locked    high while a burst owns the FIFO
//   stall_cnt saturating count of cycles with pending requests blocked by wfull
//             (present only when FIFO_WARB_STALL_CNT_EN is defined)
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int BURST    = 4
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] wdata_in,
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
`ifdef FIFO_WARB_STALL_CNT_EN
    output logic                     locked,
    output logic [15:0]              stall_cnt
`else
    output logic                     locked
`endif
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t          state;
    logic [PW-1:0]   rr_ptr, owner, start, sel, cand, pick;
    logic [4:0]      beat, beat_nx;
    logic            found, hold_own, grant;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
        return (x == PW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction
    // A burst whose owner dropped its request re-arbitrates from the owner's successor.
    assign start    = (state == S_BURST) ? nxt(owner) : rr_ptr;
    assign hold_own = (state == S_BURST) && req[owner];
    assign beat_nx  = beat + 5'd1;
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        // Scan downwards so the candidate closest to start wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(start) + k) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end
    assign pick  = hold_own ? owner : sel;
    assign grant = wrst_n && !wfull && (hold_own || found);
    assign gnt   = grant ? (NREQ'(1) << pick) : '0;
    assign winc  = grant;
    assign locked = (state == S_BURST);
    always_comb begin
        wdata = '0;
        for (int k = 0; k < NREQ; k++)
            if (grant && pick == PW'(k)) wdata = wdata_in[k*DATASIZE +: DATASIZE];
    end
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            beat   <= '0;
        end else if (grant && hold_own) begin
            beat <= beat_nx;
            if (beat_nx == 5'(BURST)) begin
                state  <= S_IDLE;
                rr_ptr <= nxt(owner);
            end
        end else if (grant) begin
            owner <= sel;
            beat  <= 5'd1;
            if (BURST > 1) begin
                state <= S_BURST;
                if (state == S_BURST) rr_ptr <= nxt(owner);
            end else begin
                state  <= S_IDLE;
                rr_ptr <= nxt(sel);
            end
        end else if (state == S_BURST && !wfull && !req[owner]) begin
            // Owner left and nobody else is asking: close the burst.
            state  <= S_IDLE;
            rr_ptr <= nxt(owner);
        end
    end
`ifdef FIFO_WARB_STALL_CNT_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) stall_cnt <= '0;
        else if (|req && wfull && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (NREQ=4, DATASIZE=8, BURST=4)
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata_in = 32'h44332211;
    logic        wfull = 1'b0;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        locked;
`ifdef FIFO_WARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int tests = 0;
    int fails = 0;

    fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .wdata_in(wdata_in), .wfull(wfull),
        .gnt(gnt), .winc(winc), .wdata(wdata),
`ifdef FIFO_WARB_STALL_CNT_EN
        .locked(locked), .stall_cnt(stall_cnt)
`else
        .locked(locked)
`endif
    );

    always #5 wclk = ~wclk;

    function automatic logic [7:0] data_of(input logic [3:0] g);
        case (g)
            4'b0001: return 8'h11;
            4'b0010: return 8'h22;
            4'b0100: return 8'h33;
            4'b1000: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step(input logic n, input logic [3:0] r, input logic f);
        @(negedge wclk);
        wrst_n = n;
        req = r;
        wfull = f;
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b1111, 1'b0);
            if ({gnt, winc, wdata, locked} !== 14'd0) begin
                fails++;
                $display("FAIL reset c%0d: gnt=%b winc=%b wdata=%h locked=%b, want all zero", c, gnt, winc, wdata, locked);
            end
            tests++;
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        logic el;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 4'b1111, 1'b0);
            eg = 4'b0001 << ((c / 4) % 4);
            el = (c % 4) != 0;
            if ({gnt, winc, wdata, locked} !== {eg, |eg, data_of(eg), el}) begin
                fails++;
                $display("FAIL round_robin c%0d: gnt=%b winc=%b wdata=%h locked=%b, want gnt=%b locked=%b", c, gnt, winc, wdata, locked, eg, el);
            end
            tests++;
        end
    endtask

    task automatic run_vec(input string name, input int n_cyc, input logic [8:0] n,
                           input logic [3:0] r [9], input logic [8:0] f,
                           input logic [3:0] eg [9], input logic [8:0] el);
        for (int c = 0; c < n_cyc; c++) begin
            step(n[c], r[c], f[c]);
            if ({gnt, winc, wdata, locked} !== {eg[c], |eg[c], data_of(eg[c]), el[c]}) begin
                fails++;
                $display("FAIL %s c%0d: gnt=%b winc=%b wdata=%h locked=%b, want gnt=%b locked=%b", name, c, gnt, winc, wdata, locked, eg[c], el[c]);
            end
            tests++;
        end
    endtask

    task automatic do_reset;
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_release;
        logic [3:0] r [9]  = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0};
        logic [3:0] eg [9] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0};
        do_reset();
        run_vec("release", 7, 9'h1FF, r, 9'h000, eg, 9'b000111110);
    endtask

    task automatic test_wfull_burst;
        logic [3:0] r [9]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0};
        logic [3:0] eg [9] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 4'b0};
        do_reset();
        run_vec("wfull_burst", 8, 9'h1FF, r, 9'b000011100, eg, 9'b001111110);
    endtask

    task automatic test_idle_cases;
        logic [3:0] r [9]  = '{4'b0000, 4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b1000, 4'b0, 4'b0, 4'b0};
        logic [3:0] eg [9] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0, 4'b0, 4'b0};
        do_reset();
        run_vec("idle_cases", 6, 9'h1FF, r, 9'b000000010, eg, 9'b000011000);
    endtask

    task automatic test_reset_mid_burst;
        logic [3:0] r [9]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        logic [3:0] eg [9] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        do_reset();
        run_vec("reset_mid_burst", 9, 9'b111110011, r, 9'h000, eg, 9'b011100010);
    endtask

`ifdef FIFO_WARB_STALL_CNT_EN
    task automatic test_stall_cnt;
        int writes = 0;
        do_reset();
        for (int c = 0; c < 70000; c++) begin
            step(1'b1, 4'b0001, 1'b1);
            if (winc) writes++;
        end
        if (writes !== 0) begin
            fails++;
            $display("FAIL stall_writes: %0d writes seen, want 0", writes);
        end
        tests++;
        if (stall_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL stall_cnt: got %h, want ffff", stall_cnt);
        end
        tests++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_release();
        test_wfull_burst();
        test_idle_cases();
        test_reset_mid_burst();
`ifdef FIFO_WARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have these parameters: NREQ, default 4, number of write requesters (2..8); DATASIZE, default 8, FIFO data word width; BURST, default 4, maximum consecutive beats per grant (1..16).
REQ-002 wclk  input  1  write-domain clock; all state SHALL be clocked on its rising edge.
REQ-003 wrst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-005 wdata_in  input  NREQ*DATASIZE  flattened requester data; slice [i*DATASIZE +: DATASIZE] belongs to requester i.
REQ-006 wfull  input  1  FIFO full flag from the write-pointer logic.
REQ-007 gnt  output  NREQ  one-hot accept; gnt[i]=1 means requester i's word is written this cycle.
REQ-008 winc  output  1  FIFO write increment, equal to |gnt.
REQ-009 wdata  output  DATASIZE  selected requester data to FIFO memory; all zeros when winc=0.
REQ-010 locked  output  1  high while in state BURST.

Function
REQ-011 gnt, winc and wdata SHALL be combinational from the current state, req and wfull, giving zero-cycle latency; the memory captures wdata on the same wclk edge.
REQ-012 When wfull=1, gnt, winc and wdata SHALL be 0 in every state, with no requester dropped or reordered.
REQ-013 FSM states: IDLE and BURST; registers: state, rr_ptr (log2 NREQ bits), owner (log2 NREQ bits), beat (5 bits).
REQ-014 IDLE with any req=1 and wfull=0: grant the first requester found scanning rr_ptr, rr_ptr+1, ... modulo NREQ; set owner to it and beat to 1.
REQ-015 IDLE transition: if BURST>1, go to BURST; otherwise stay in IDLE and set rr_ptr=owner+1 modulo NREQ.
REQ-016 BURST with req[owner]=1 and wfull=0: grant owner and increment beat; when beat reaches BURST after that grant, go to IDLE with rr_ptr=owner+1.
REQ-017 BURST with req[owner]=0: release without a bubble; perform the IDLE arbitration of REQ-014/015 in that cycle, starting from rr_ptr=owner+1 (owner excluded).
REQ-018 BURST with wfull=1: hold state, owner and beat; the burst resumes when wfull deasserts.
REQ-019 rr_ptr SHALL wrap from NREQ-1 to 0; requests arriving mid-burst SHALL wait, so no requester starves for more than (NREQ-1)*BURST granted beats.
REQ-020 gnt SHALL never have more than one bit set, and winc=1 only when wfull=0.

Reset
REQ-021 While wrst_n=0: state=IDLE, rr_ptr=0, owner=0, beat=0, locked=0, and gnt, winc and wdata forced to 0 regardless of req.
REQ-022 Reset asserted mid-burst SHALL abandon the burst immediately; after release, the first grant is to the lowest-indexed active requester.

Configuration
REQ-023 With FIFO_WARB_STALL_CNT_EN defined: an extra output stall_cnt [15:0] SHALL count cycles where |req=1 and wfull=1.
REQ-024 stall_cnt SHALL saturate at 16'hFFFF and reset to 0 on wrst_n.
REQ-025 Without FIFO_WARB_STALL_CNT_EN: the stall_cnt port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-026 Reset release with req=4'b1111 held, wfull=0, BURST=4: gnt=0001 for 4 cycles, then 0010 for 4, then 0100 for 4, then 1000 for 4, then back to 0001.
REQ-027 req=4'b0101, requester 0 drops req after 2 beats: the next cycle gnt=0100 with no idle cycle; locked stays 1.
REQ-028 Mid-burst owner=1, beat=2, wfull pulses high for 3 cycles: winc=0 for those 3 cycles, then gnt=0010 resumes for exactly 2 more beats.
REQ-029 wrst_n asserted during a burst with req=4'b1000 held: gnt=0 while in reset; first grant after release is 1000 with beat=1.
REQ-030 With FIFO_WARB_STALL_CNT_EN, req=4'b0001 and wfull=1 for 70000 cycles: stall_cnt=16'hFFFF and no write occurs.
